// File: rtl/next_line_prefetcher_if.sv
// next_line_prefetcher_if: cache-control, arbiter and buffer signals of the next-line prefetcher
interface next_line_prefetcher_if;
    logic         trig_valid;
    logic [31:0]  trig_address;
    logic         inv_valid;
    logic [31:0]  inv_address;
    logic [31:0]  lookup_address;
    logic         prefetch_ack;
    logic [255:0] pf_mem_rdata;
    logic         pf_mem_resp;
    logic         pf_mem_read;
    logic [31:0]  pf_mem_address;
    logic [255:0] prefetch_rdata;
    logic [31:0]  prefetch_address;
    logic         prefetch_ready;
    logic         pf_hit;
    logic [15:0]  pf_issued;
    modport slave (
        input  trig_valid, trig_address, inv_valid, inv_address, lookup_address,
               prefetch_ack, pf_mem_rdata, pf_mem_resp,
        output pf_mem_read, pf_mem_address, prefetch_rdata, prefetch_address,
               prefetch_ready, pf_hit, pf_issued
    );
    modport master (
        output trig_valid, trig_address, inv_valid, inv_address, lookup_address,
               prefetch_ack, pf_mem_rdata, pf_mem_resp,
        input  pf_mem_read, pf_mem_address, prefetch_rdata, prefetch_address,
               prefetch_ready, pf_hit, pf_issued
    );
endinterface

// File: rtl/next_line_prefetcher.sv
// next_line_prefetcher: fetches line+PF_DIST on each demand miss into a one-line buffer.
// Define PF_BUFFER_HIT_EN to build the combinational buffer-hit compare on pf_hit.
module next_line_prefetcher #(
    parameter int s_offset = 5,
    parameter int PF_DIST  = 1
) (
    input logic clk,
    input logic rst,
    next_line_prefetcher_if.slave bus
);
    localparam int LW = 32 - s_offset;
    // State bits double as the registered pf_mem_read / prefetch_ready outputs
    typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, HOLD = 2'b10} state_t;
    state_t state, state_n;
    logic [LW-1:0] target;
    logic stale, inv_req, inv_buf, drop, issue, accept;
    assign target  = bus.trig_address[31:s_offset] + LW'(PF_DIST);
    assign inv_req = bus.inv_valid && bus.inv_address[31:s_offset] == bus.pf_mem_address[31:s_offset];
    assign inv_buf = bus.inv_valid && bus.inv_address[31:s_offset] == bus.prefetch_address[31:s_offset];
    assign drop    = bus.prefetch_ack || inv_buf;
    always_comb begin
        state_n = state == IDLE  ? (bus.trig_valid ? FETCH : IDLE) :
                  state == FETCH ? (!bus.pf_mem_resp ? FETCH : (stale || inv_req) ? IDLE : HOLD) :
                  (bus.trig_valid && (drop || target != bus.prefetch_address[31:s_offset])) ? FETCH :
                  drop ? IDLE : HOLD;
        issue  = state != FETCH && state_n == FETCH;
        accept = state == FETCH && state_n == HOLD;
    end
    assign bus.pf_mem_read    = state[0];
    assign bus.prefetch_ready = state[1];
`ifdef PF_BUFFER_HIT_EN
    assign bus.pf_hit = bus.prefetch_ready &&
                        bus.lookup_address[31:s_offset] == bus.prefetch_address[31:s_offset];
`else
    assign bus.pf_hit = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            stale                <= 1'b0;
            bus.pf_mem_address   <= '0;
            bus.prefetch_address <= '0;
            bus.prefetch_rdata   <= '0;
            bus.pf_issued        <= '0;
        end else begin
            state <= state_n;
            if (issue) begin
                bus.pf_mem_address <= {target, {s_offset{1'b0}}};
                stale              <= 1'b0;
                if (bus.pf_issued != 16'hFFFF) bus.pf_issued <= bus.pf_issued + 16'd1;
            end else if (state == FETCH && inv_req) begin
                stale <= 1'b1;
            end
            if (accept) begin
                bus.prefetch_rdata   <= bus.pf_mem_rdata;
                bus.prefetch_address <= bus.pf_mem_address;
            end
        end
    end
endmodule

// File: tb/tb_next_line_prefetcher.sv
// tb_next_line_prefetcher: directed and random stimulus against an event-level buffer model.
module tb_next_line_prefetcher;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    next_line_prefetcher_if bus();
    next_line_prefetcher dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int passes = 0;
    int checks = 0;
    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // Model: an outstanding request (address + stale) and a buffer (valid, address, data)
    bit           m_fetching, m_stale, m_valid;
    logic [31:0]  m_req, m_buf_addr;
    logic [255:0] m_buf_data;
    int           m_issued;
    function automatic logic [31:0] line_of(logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction
    always @(posedge clk or posedge rst) begin : model
        logic [26:0] tl;
        logic [31:0] tgt;
        bit still_valid;
        if (rst) begin
            m_fetching <= 0; m_stale <= 0; m_valid <= 0;
            m_req <= '0; m_buf_addr <= '0; m_buf_data <= '0; m_issued <= 0;
        end else begin
            tl  = bus.trig_address[31:5] + 27'd1;
            tgt = {tl, 5'b0};
            if (m_fetching) begin
                if (bus.pf_mem_resp) begin
                    m_fetching <= 0;
                    if (!(m_stale || (bus.inv_valid && line_of(bus.inv_address) == m_req))) begin
                        m_valid    <= 1;
                        m_buf_addr <= m_req;
                        m_buf_data <= bus.pf_mem_rdata;
                    end
                end else if (bus.inv_valid && line_of(bus.inv_address) == m_req) begin
                    m_stale <= 1;
                end
            end else begin
                still_valid = m_valid && !bus.prefetch_ack &&
                              !(bus.inv_valid && line_of(bus.inv_address) == m_buf_addr);
                if (bus.trig_valid && !(still_valid && tgt == m_buf_addr)) begin
                    m_fetching <= 1;
                    m_stale    <= 0;
                    m_valid    <= 0;
                    m_req      <= tgt;
                    m_issued   <= m_issued < 65535 ? m_issued + 1 : 65535;
                end else begin
                    m_valid <= still_valid;
                end
            end
        end
    end
    always @(negedge clk) begin
        bit exp_hit;
`ifdef PF_BUFFER_HIT_EN
        exp_hit = m_valid && line_of(bus.lookup_address) == m_buf_addr;
`else
        exp_hit = 0;
`endif
        check("pf_mem_read", bus.pf_mem_read, m_fetching);
        check("pf_mem_address", bus.pf_mem_address, m_req);
        check("prefetch_ready", bus.prefetch_ready, m_valid);
        check("prefetch_address", bus.prefetch_address, m_buf_addr);
        check("prefetch_rdata", bus.prefetch_rdata, m_buf_data);
        check("pf_issued", bus.pf_issued, m_issued);
        check("pf_hit", bus.pf_hit, exp_hit);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear();
        bus.trig_valid = 0; bus.inv_valid = 0; bus.prefetch_ack = 0; bus.pf_mem_resp = 0;
    endtask
    task automatic check_reset_outputs(string tag);
        check({tag, "_read"}, bus.pf_mem_read, 1'b0);
        check({tag, "_maddr"}, bus.pf_mem_address, 32'h0);
        check({tag, "_ready"}, bus.prefetch_ready, 1'b0);
        check({tag, "_paddr"}, bus.prefetch_address, 32'h0);
        check({tag, "_rdata"}, bus.prefetch_rdata, 256'h0);
        check({tag, "_issued"}, bus.pf_issued, 16'h0);
        check({tag, "_hit"}, bus.pf_hit, 1'b0);
    endtask
    function automatic logic [31:0] rnd_addr();
        logic [31:0] l;
        l = $urandom_range(0, 7) == 7 ? 32'h07FF_FFFF : 32'($urandom_range(0, 5));
        return {l[26:0], 5'($urandom)};
    endfunction
    initial begin
        clear();
        bus.trig_address = '0; bus.inv_address = '0; bus.lookup_address = '0; bus.pf_mem_rdata = '0;
        #1 rst = 1;
        #12 check_reset_outputs("reset");
        rst = 0;
        tick();
        bus.trig_valid = 1; bus.trig_address = 32'h0000_1000;
        tick(); clear();
        check("first_read", bus.pf_mem_read, 1'b1);
        check("first_maddr", bus.pf_mem_address, 32'h0000_1020);
        bus.pf_mem_resp = 1; bus.pf_mem_rdata = {32{8'hA5}};
        tick(); clear();
        check("first_ready", bus.prefetch_ready, 1'b1);
        check("first_paddr", bus.prefetch_address, 32'h0000_1020);
        check("first_rdata", bus.prefetch_rdata, {32{8'hA5}});
        check("first_issued", bus.pf_issued, 16'd1);
        check("first_read_low", bus.pf_mem_read, 1'b0);
        bus.trig_valid = 1; bus.trig_address = 32'hFFFF_FFE0;
        tick(); clear();
        check("wrap_maddr", bus.pf_mem_address, 32'h0);
        check("wrap_read", bus.pf_mem_read, 1'b1);
        bus.pf_mem_resp = 1; tick(); clear();
        bus.prefetch_ack = 1; tick(); clear();
        check("ack_ready", bus.prefetch_ready, 1'b0);
        bus.trig_valid = 1; bus.trig_address = 32'h0000_2000; tick(); clear();
        bus.inv_valid = 1; bus.inv_address = 32'h0000_2020; tick(); clear();
        bus.pf_mem_resp = 1; tick(); clear();
        check("stale_ready", bus.prefetch_ready, 1'b0);
        check("stale_read", bus.pf_mem_read, 1'b0);
        bus.trig_valid = 1; bus.trig_address = 32'h0000_3000; tick(); clear();
        bus.pf_mem_resp = 1; tick(); clear();
        check("hold3_paddr", bus.prefetch_address, 32'h0000_3020);
        bus.trig_valid = 1; bus.trig_address = 32'h0000_3000; tick(); clear();
        check("dup_issued", bus.pf_issued, 16'd4);
        check("dup_read", bus.pf_mem_read, 1'b0);
        check("dup_ready", bus.prefetch_ready, 1'b1);
        bus.trig_valid = 1; bus.trig_address = 32'h0000_4000; tick(); clear();
        check("new_read", bus.pf_mem_read, 1'b1);
        check("new_maddr", bus.pf_mem_address, 32'h0000_4020);
        bus.pf_mem_resp = 1; tick(); clear();
        bus.prefetch_ack = 1; bus.trig_valid = 1; bus.trig_address = 32'h0000_5000; tick(); clear();
        check("acktrig_ready", bus.prefetch_ready, 1'b0);
        check("acktrig_maddr", bus.pf_mem_address, 32'h0000_5020);
        check("acktrig_issued", bus.pf_issued, 16'd6);
        bus.pf_mem_resp = 1; tick(); clear();
        bus.trig_valid = 1; bus.trig_address = 32'h0000_6000; tick(); clear();
        bus.pf_mem_resp = 1; tick(); clear();
        bus.lookup_address = 32'h0000_6034; #1;
`ifdef PF_BUFFER_HIT_EN
        check("hit_6034", bus.pf_hit, 1'b1);
`else
        check("hit_6034", bus.pf_hit, 1'b0);
`endif
        bus.lookup_address = 32'h0000_6040; #1;
        check("hit_6040", bus.pf_hit, 1'b0);
        bus.trig_valid = 1; bus.trig_address = 32'h0000_7000; tick(); clear();
        check("pre_rst_read", bus.pf_mem_read, 1'b1);
        #1 rst = 1;
        #1 check_reset_outputs("midrst");
        rst = 0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            bus.trig_valid     = $urandom_range(0, 3) == 0;
            bus.trig_address   = rnd_addr();
            bus.inv_valid      = $urandom_range(0, 5) == 0;
            bus.inv_address    = rnd_addr();
            bus.prefetch_ack   = $urandom_range(0, 4) == 0;
            bus.pf_mem_resp    = $urandom_range(0, 2) == 0;
            bus.pf_mem_rdata   = {8{$urandom}};
            bus.lookup_address = rnd_addr();
            if (i == 1500) begin
                #1 rst = 1;
                #1 check("rand_rst_read", bus.pf_mem_read, 1'b0);
                rst = 0;
            end
            tick();
        end
        clear();
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
